// File: rtl/motor602_uart_pkg.sv
// motor602_uart_pkg: shared types, command bytes and baud helper for the motor602 UART blocks
//   rx_state_e    receiver FSM states
//   CMD_*         ASCII command byte values
//   clks_per_bit  integer clocks per bit for a given clock and line rate
package motor602_uart_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} rx_state_e;
   localparam logic [7:0] CMD_START = 8'h53;
   localparam logic [7:0] CMD_STOP  = 8'h58;
   localparam logic [7:0] CMD_INV   = 8'h52;
   localparam logic [7:0] CMD_FINC  = 8'h2B;
   localparam logic [7:0] CMD_FDEC  = 8'h2D;
   localparam logic [7:0] CMD_PINC  = 8'h50;
   localparam logic [7:0] CMD_PDEC  = 8'h70;
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction
endpackage

// File: rtl/motor602_uart_cmd_dec.sv
// motor602_uart_cmd_dec: registered decode of received bytes into motor control signals
//   clk50mhzI, nResetI       clock, async active-low reset
//   rx_byte_i, rx_valid_i    received byte and its one-cycle strobe
//   m3startO, m3invRotateO   levels (set/clear by S/X, toggle by R)
//   m3forceStopO, m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo   one-cycle pulses
module motor602_uart_cmd_dec
   import motor602_uart_pkg::*;
(
   input  logic       clk50mhzI,
   input  logic       nResetI,
   input  logic [7:0] rx_byte_i,
   input  logic       rx_valid_i,
   output logic       m3startO,
   output logic       m3forceStopO,
   output logic       m3invRotateO,
   output logic       m3freqINCo,
   output logic       m3freqDECo,
   output logic       m3powerINCo,
   output logic       m3powerDECo
);
   logic       start_q, start_d, inv_q, inv_d;
   logic [4:0] pulse_q, pulse_d;
   always_comb begin
      pulse_d = rx_valid_i ? {rx_byte_i == CMD_STOP, rx_byte_i == CMD_FINC, rx_byte_i == CMD_FDEC,
                              rx_byte_i == CMD_PINC, rx_byte_i == CMD_PDEC} : 5'b0;
      // 'X' wins over the held start level; 'S' while already started is a no-op
      start_d = (rx_valid_i && rx_byte_i == CMD_START) ? 1'b1 : pulse_d[4] ? 1'b0 : start_q;
      inv_d   = inv_q ^ (rx_valid_i && rx_byte_i == CMD_INV);
   end
   always_ff @(posedge clk50mhzI or negedge nResetI) begin
      if (!nResetI) begin
         start_q <= 1'b0;
         inv_q   <= 1'b0;
         pulse_q <= 5'b0;
      end else begin
         start_q <= start_d;
         inv_q   <= inv_d;
         pulse_q <= pulse_d;
      end
   end
   assign m3startO     = start_q;
   assign m3invRotateO = inv_q;
   assign {m3forceStopO, m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo} = pulse_q;
endmodule

// File: rtl/motor602_uart_cmd_rx.sv
// motor602_uart_cmd_rx: 8N1 UART receiver decoding single-character motor commands
//   clk50mhzI, nResetI   system clock, async active-low reset
//   uRxI                 serial input, idle high, asynchronous to clk
//   rxByteO, rxValidO    last good byte and its one-cycle update strobe
//   frameErrO            one-cycle strobe when the stop bit samples low
//   m3*                  command outputs from motor602_uart_cmd_dec
module motor602_uart_cmd_rx
   import motor602_uart_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
   input  logic       clk50mhzI,
   input  logic       nResetI,
   input  logic       uRxI,
   output logic [7:0] rxByteO,
   output logic       rxValidO,
   output logic       frameErrO,
   output logic       m3startO,
   output logic       m3forceStopO,
   output logic       m3invRotateO,
   output logic       m3freqINCo,
   output logic       m3freqDECo,
   output logic       m3powerINCo,
   output logic       m3powerDECo
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   rx_state_e     state_q, state_d;
   logic          sync_q, rxs_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d, byte_q, byte_d;
   logic          valid_q, valid_d, ferr_q, ferr_d, tick;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      tick    = cnt_q == '0;
      case (state_q)
         // IDLE is only ever entered with rxS high, so a low level here is the falling edge
         ST_IDLE: if (!rxs_q) begin
            state_d = ST_START;
            cnt_d   = HALF;
         end
         ST_START: if (tick) begin
            state_d = rxs_q ? ST_IDLE : ST_DATA;
            cnt_d   = FULL;
            bit_d   = 3'd0;
         end
         ST_DATA: if (tick) begin
            shift_d = {rxs_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            cnt_d   = FULL;
            if (bit_q == 3'd7) state_d = ST_STOP;
         end
         ST_STOP: if (tick) begin
            state_d = rxs_q ? ST_IDLE : ST_BREAK;
            valid_d = rxs_q;
            ferr_d  = !rxs_q;
            byte_d  = rxs_q ? shift_q : byte_q;
         end
         ST_BREAK: if (rxs_q) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk50mhzI or negedge nResetI) begin
      if (!nResetI) begin
         sync_q  <= 1'b1;
         rxs_q   <= 1'b1;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         byte_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= uRxI;
         rxs_q   <= sync_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end
   assign rxByteO   = byte_q;
   assign rxValidO  = valid_q;
   assign frameErrO = ferr_q;
   motor602_uart_cmd_dec u_dec (
      .clk50mhzI    (clk50mhzI),
      .nResetI      (nResetI),
      .rx_byte_i    (byte_q),
      .rx_valid_i   (valid_q),
      .m3startO     (m3startO),
      .m3forceStopO (m3forceStopO),
      .m3invRotateO (m3invRotateO),
      .m3freqINCo   (m3freqINCo),
      .m3freqDECo   (m3freqDECo),
      .m3powerINCo  (m3powerINCo),
      .m3powerDECo  (m3powerDECo)
   );
endmodule

// File: tb/tb_motor602_uart_cmd_rx.sv
// tb_motor602_uart_cmd_rx: scoreboard bench driving serial frames against a command-level model
`timescale 1ns/1ps
module tb_motor602_uart_cmd_rx;
   import motor602_uart_pkg::*;
   localparam int CPB  = 50;
   localparam int TCLK = 10;
   localparam int TBIT = CPB * TCLK;
   localparam int LAT  = 2 + CPB / 2 + 9 * CPB;
   logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_valid, ferr, start, fstop, inv, finc, fdec, pinc, pdec;
   typedef struct {bit err; logic [7:0] b; longint t0; bit lat;} ev_t;
   ev_t        exp_q[$];
   ev_t        e;
   int         checks = 0, errors = 0;
   bit         m_start = 0, m_inv = 0, pend = 0;
   logic [7:0] pend_b, last_good = 8'h00;
   logic [4:0] ep;
   longint     l;
   logic [7:0] cmds [8];

   always #5 clk = ~clk;

   motor602_uart_cmd_rx #(.CLK_HZ(50_000_000), .BAUD(1_000_000), .CLKS_PER_BIT(CPB)) dut (
      .clk50mhzI(clk), .nResetI(rst_n), .uRxI(rx), .rxByteO(rx_byte), .rxValidO(rx_valid),
      .frameErrO(ferr), .m3startO(start), .m3forceStopO(fstop), .m3invRotateO(inv),
      .m3freqINCo(finc), .m3freqDECo(fdec), .m3powerINCo(pinc), .m3powerDECo(pdec)
   );

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit stop, input int tbit, input bit push);
      ev_t x;
      x.err = !stop; x.b = b; x.t0 = $time; x.lat = (tbit == TBIT);
      if (push) exp_q.push_back(x);
      rx = 1'b0;
      #(tbit);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(tbit);
      end
      rx = stop;
      #(tbit);
   endtask

   // Monitor: command model applied one cycle after each good byte, pulse vector checked every cycle
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         m_start = 0; m_inv = 0; pend = 0; last_good = 8'h00;
         chk({rx_byte, rx_valid, ferr, start, fstop, inv, finc, fdec, pinc, pdec} == 17'h0,
             "reset_outs", {rx_byte, rx_valid, ferr, start, fstop, inv, finc, fdec, pinc, pdec}, 0);
      end else begin
         ep = 5'b0;
         if (pend) begin
            if (pend_b == CMD_START) m_start = 1;
            if (pend_b == CMD_STOP) begin m_start = 0; ep[4] = 1; end
            if (pend_b == CMD_INV) m_inv = ~m_inv;
            ep[3] = pend_b == CMD_FINC;
            ep[2] = pend_b == CMD_FDEC;
            ep[1] = pend_b == CMD_PINC;
            ep[0] = pend_b == CMD_PDEC;
            pend = 0;
         end
         chk({fstop, finc, fdec, pinc, pdec, start, inv} == {ep, m_start, m_inv}, "cmd_outs",
             {fstop, finc, fdec, pinc, pdec, start, inv}, {ep, m_start, m_inv});
         if (rx_valid || ferr) begin
            if (exp_q.size() == 0) chk(0, "unexpected_strobe", {rx_valid, ferr}, 0);
            else begin
               e = exp_q.pop_front();
               chk({rx_valid, ferr} == {!e.err, e.err}, "strobe_kind", {rx_valid, ferr}, {!e.err, e.err});
               if (!e.err) begin
                  chk(rx_byte == e.b, "rx_byte", rx_byte, e.b);
                  last_good = e.b;
                  pend = 1;
                  pend_b = e.b;
                  if (e.lat) begin
                     l = ($time - e.t0) / TCLK;
                     chk(l >= LAT - 1 && l <= LAT + 2, "latency", l, LAT);
                  end
               end else chk(rx_byte == last_good, "byte_held", rx_byte, last_good);
            end
         end
      end
   end

   initial begin
      cmds = '{CMD_START, CMD_STOP, CMD_INV, CMD_FINC, CMD_FDEC, CMD_PINC, CMD_PDEC, 8'h00};
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b1;
      // idle line
      #(2000 * TCLK);
      chk({rx_byte, rx_valid, ferr, start, fstop, inv, finc, fdec, pinc, pdec} == 17'h0, "idle_outs",
          {rx_byte, rx_valid, ferr, start, fstop, inv, finc, fdec, pinc, pdec}, 0);
      // start then stop
      send(CMD_START, 1, TBIT, 1);
      chk(start == 1'b1, "start_level", start, 1);
      send(CMD_STOP, 1, TBIT, 1);
      chk(start == 1'b0, "stop_level", start, 0);
      // three back-to-back inverts
      repeat (3) send(CMD_INV, 1, TBIT, 1);
      #(TBIT);
      chk(inv == 1'b1, "inv_final", inv, 1);
      // framing error, held-low line, recovery
      send(CMD_FINC, 0, TBIT, 1);
      #(20 * TBIT);
      rx = 1'b1;
      #(2 * TBIT);
      send(CMD_PDEC, 1, TBIT, 1);
      // short glitch, then +-2% baud error
      rx = 1'b0;
      #(15 * TCLK);
      rx = 1'b1;
      #(2 * TBIT);
      send(CMD_FDEC, 1, TBIT * 102 / 100, 1);
      send(CMD_PINC, 1, TBIT * 98 / 100, 1);
      #(TBIT);
      // reset in the middle of the data bits of 'P'
      rx = 1'b0;
      #(TBIT);
      for (int i = 0; i < 3; i++) begin
         rx = CMD_PINC[i];
         #(TBIT);
      end
      #(TBIT / 2);
      rst_n = 1'b0;
      rx = 1'b1;
      #(5 * TCLK);
      rst_n = 1'b1;
      #(2 * TBIT);
      send(CMD_FINC, 1, TBIT, 1);
      chk(rx_byte == CMD_FINC, "after_reset_byte", rx_byte, CMD_FINC);
      // randomized traffic
      for (int n = 0; n < 14; n++) begin
         logic [7:0] b;
         bit sb;
         b = cmds[$urandom_range(0, 7)];
         if (b == 8'h00) b = 8'($urandom);
         sb = $urandom_range(0, 5) != 0;
         send(b, sb, TBIT, 1);
         if (!sb) begin
            rx = 1'b1;
            #(TBIT);
         end
         #($urandom_range(0, 2) * TBIT);
      end
      repeat (3 * CPB) @(negedge clk);
      chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
